// File: rtl/tap_controller_pkg.sv
// Shared TAP definitions: instruction opcodes, data-register selects and the
// 16-state 1149.1 controller encoding.
package tap_controller_pkg;

    localparam int unsigned IR_W        = 4;
    localparam int unsigned TAP_STATE_W = 4;

    // Instruction opcodes loaded through the IR column.
    localparam logic [IR_W-1:0] E_EXTEST  = IR_W'('h0);
    localparam logic [IR_W-1:0] E_SAMPLE  = IR_W'('h1);
    localparam logic [IR_W-1:0] E_IDCODE  = IR_W'('h2);
    localparam logic [IR_W-1:0] E_BYPASS  = IR_W'('hF);

    // Data register chosen by the active instruction.
    localparam logic [1:0] D_BYPASS   = 2'd0;
    localparam logic [1:0] D_IDCODE   = 2'd1;
    localparam logic [1:0] D_BOUNDARY = 2'd2;

    typedef enum logic [TAP_STATE_W-1:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    // True for every state in the IR column, Select-IR-Scan included.
    function automatic logic is_ir_column(input tap_state_t s);
        case (s)
            SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR,
            PAUSE_IR, EXIT2_IR, UPDATE_IR: is_ir_column = 1'b1;
            default:                       is_ir_column = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tap_controller_if.sv
// Pin- and chain-side signals of the TAP controller. The master side drives
// tms and the chain serial outputs; the slave side is the controller.
interface tap_controller_if;
    import tap_controller_pkg::*;

    logic       tms;
    logic       ir_tdo;
    logic       dr_tdo;

    logic       tl_reset;
    logic       captureIR;
    logic       shiftIR;
    logic       updateIR;
    logic       captureDR;
    logic       shiftDR;
    logic       updateDR;
    logic       ir_clk_en;
    logic       dr_clk_en;
    logic       select;
    logic       tdo;
    logic       tdo_en;
    tap_state_t state;

    modport master (
        output tms, ir_tdo, dr_tdo,
        input  tl_reset, captureIR, shiftIR, updateIR,
               captureDR, shiftDR, updateDR,
               ir_clk_en, dr_clk_en, select, tdo, tdo_en, state
    );

    modport slave (
        input  tms, ir_tdo, dr_tdo,
        output tl_reset, captureIR, shiftIR, updateIR,
               captureDR, shiftDR, updateDR,
               ir_clk_en, dr_clk_en, select, tdo, tdo_en, state
    );

endinterface

// File: rtl/tap_tdo_stage.sv
// TDO output stage: selects the IR or DR serial stream while shifting and
// registers pin data/enable on the tck edge chosen by TDO_NEGEDGE.
module tap_tdo_stage #(
    parameter bit TDO_NEGEDGE = 1'b1
) (
    input  logic tck,
    input  logic trst,
    input  logic shift_ir_i,
    input  logic shift_dr_i,
    input  logic ir_tdo_i,
    input  logic dr_tdo_i,
    output logic tdo_o,
    output logic tdo_en_o
);

    logic tdo_d;
    logic tdo_q;
    logic tdo_en_d;
    logic tdo_en_q;

    // Pin keeps the last shifted bit whenever neither chain is shifting.
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = shift_ir_i | shift_dr_i;
        if (shift_ir_i) begin
            tdo_d = ir_tdo_i;
        end else if (shift_dr_i) begin
            tdo_d = dr_tdo_i;
        end
    end

    generate
        if (TDO_NEGEDGE) begin : g_negedge
            always_ff @(negedge tck or posedge trst) begin
                if (trst) begin
                    tdo_q    <= 1'b0;
                    tdo_en_q <= 1'b0;
                end else begin
                    tdo_q    <= tdo_d;
                    tdo_en_q <= tdo_en_d;
                end
            end
        end else begin : g_posedge
            always_ff @(posedge tck or posedge trst) begin
                if (trst) begin
                    tdo_q    <= 1'b0;
                    tdo_en_q <= 1'b0;
                end else begin
                    tdo_q    <= tdo_d;
                    tdo_en_q <= tdo_en_d;
                end
            end
        end
    endgenerate

    assign tdo_o    = tdo_q;
    assign tdo_en_o = tdo_en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TMS-driven FSM, chain strobes and
// IR/DR select decoded from the registered state, plus the TDO pin stage.
module tap_controller
    import tap_controller_pkg::*;
#(
    parameter bit TDO_NEGEDGE = 1'b1
) (
    input  logic            tck,
    input  logic            trst,
    tap_controller_if.slave tap
);

    tap_state_t state_q;
    tap_state_t state_d;

    logic tl_reset_c;
    logic capture_ir_c;
    logic shift_ir_c;
    logic update_ir_c;
    logic capture_dr_c;
    logic shift_dr_c;
    logic update_dr_c;
    logic select_c;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Decodes depend only on state_q, so they change only after posedge tck.
    always_comb begin
        state_d      = state_q;
        tl_reset_c   = 1'b0;
        capture_ir_c = 1'b0;
        shift_ir_c   = 1'b0;
        update_ir_c  = 1'b0;
        capture_dr_c = 1'b0;
        shift_dr_c   = 1'b0;
        update_dr_c  = 1'b0;
        select_c     = is_ir_column(state_q);

        case (state_q)
            TEST_LOGIC_RESET: begin
                tl_reset_c = 1'b1;
                state_d    = tap.tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            end
            RUN_TEST_IDLE:  state_d = tap.tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
            SELECT_DR_SCAN: state_d = tap.tms ? SELECT_IR_SCAN : CAPTURE_DR;
            SELECT_IR_SCAN: state_d = tap.tms ? TEST_LOGIC_RESET : CAPTURE_IR;

            CAPTURE_DR: begin
                capture_dr_c = 1'b1;
                state_d      = tap.tms ? EXIT1_DR : SHIFT_DR;
            end
            SHIFT_DR: begin
                shift_dr_c = 1'b1;
                state_d    = tap.tms ? EXIT1_DR : SHIFT_DR;
            end
            EXIT1_DR: state_d = tap.tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR: state_d = tap.tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tap.tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: begin
                update_dr_c = 1'b1;
                state_d     = tap.tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
            end

            CAPTURE_IR: begin
                capture_ir_c = 1'b1;
                state_d      = tap.tms ? EXIT1_IR : SHIFT_IR;
            end
            SHIFT_IR: begin
                shift_ir_c = 1'b1;
                state_d    = tap.tms ? EXIT1_IR : SHIFT_IR;
            end
            EXIT1_IR: state_d = tap.tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR: state_d = tap.tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tap.tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: begin
                update_ir_c = 1'b1;
                state_d     = tap.tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
            end

            default: state_d = TEST_LOGIC_RESET;
        endcase
    end

    tap_tdo_stage #(
        .TDO_NEGEDGE (TDO_NEGEDGE)
    ) u_tdo_stage (
        .tck        (tck),
        .trst       (trst),
        .shift_ir_i (shift_ir_c),
        .shift_dr_i (shift_dr_c),
        .ir_tdo_i   (tap.ir_tdo),
        .dr_tdo_i   (tap.dr_tdo),
        .tdo_o      (tap.tdo),
        .tdo_en_o   (tap.tdo_en)
    );

    assign tap.tl_reset  = tl_reset_c;
    assign tap.captureIR = capture_ir_c;
    assign tap.shiftIR   = shift_ir_c;
    assign tap.updateIR  = update_ir_c;
    assign tap.captureDR = capture_dr_c;
    assign tap.shiftDR   = shift_dr_c;
    assign tap.updateDR  = update_dr_c;
    assign tap.ir_clk_en = capture_ir_c | shift_ir_c;
    assign tap.dr_clk_en = capture_dr_c | shift_dr_c;
    assign tap.select    = select_c;
    assign tap.state     = state_q;

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine that sequences the instruction register and the data-register chains.
- Decodes TMS on the rising edge of tck into the 16 standard states.
- Drives capture/shift/update strobes, the test-logic reset, and the IR/DR select.
- Owns the falling-edge TDO output stage that muxes IR and DR serial outputs onto the pin.

Parameters:
- TDO_NEGEDGE, 1, 1: tdo/tdo_en registered on the falling edge of tck (1149.1 compliant). 0: registered on the rising edge (scan/emulation builds only).

Ports:
- tck  input  1  test clock, the only clock.
- trst  input  1  asynchronous, active-high reset; forces Test-Logic-Reset.
- tms  input  1  test mode select, sampled on posedge tck.
- ir_tdo  input  1  serial out of instruction register.
- dr_tdo  input  1  serial out of the currently selected data register.
- tl_reset  output  1  high while state is Test-Logic-Reset.
- captureIR  output  1  high in Capture-IR.
- shiftIR  output  1  high in Shift-IR.
- updateIR  output  1  high in Update-IR.
- captureDR  output  1  high in Capture-DR.
- shiftDR  output  1  high in Shift-DR.
- updateDR  output  1  high in Update-DR.
- ir_clk_en  output  1  high in Capture-IR or Shift-IR; top level gates tck_ir with it.
- dr_clk_en  output  1  high in Capture-DR or Shift-DR.
- select  output  1  1 = IR path (state in the IR column, incl. Select-IR-Scan); 0 = DR path.
- tdo  output  1  registered serial output.
- tdo_en  output  1  registered pad output enable.
- state  output  4  current state, for debug.

Behaviour:
- State encoding (4-bit, standard):
  - Exit2-DR 0x0, Exit1-DR 0x1, Shift-DR 0x2, Pause-DR 0x3
  - Select-IR-Scan 0x4, Update-DR 0x5, Capture-DR 0x6, Select-DR-Scan 0x7
  - Exit2-IR 0x8, Exit1-IR 0x9, Shift-IR 0xA, Pause-IR 0xB
  - Run-Test/Idle 0xC, Update-IR 0xD, Capture-IR 0xE, Test-Logic-Reset 0xF
- State register: updated on posedge tck; trst asynchronously sets it to 0xF.
- Transitions (written as tms=0 target / tms=1 target):
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - SelIR: CapIR / TLR.
  - Cap*: Shift* / Exit1*.
  - Shift*: Shift* / Exit1*.
  - Exit1*: Pause* / Update*.
  - Pause*: Pause* / Exit2*.
  - Exit2*: Shift* / Update*.
  - Update*: RTI / SelDR (both IR and DR).
- Five consecutive tms=1 clocks reach TLR from any state. Further tms=1 holds TLR.
- All strobes, clock enables and select are combinational decodes of the registered state. They are glitch-free because the state changes only on posedge.
- Strobe timing:
  - Capture and shift strobes are valid across the posedge at which the target register acts.
  - Update strobes are high for the whole Update state, so the downstream falling-edge latch samples them mid-state.
- Reset values (trst high, state=0xF):
  - tl_reset=1, select=0.
  - All capture/shift/update strobes and clock enables = 0.
  - tdo=0, tdo_en=0.
- TDO stage (TDO_NEGEDGE=1): on negedge tck:
  - tdo <= shiftIR ? ir_tdo : (shiftDR ? dr_tdo : tdo), i.e. tdo holds outside shift.
  - tdo_en <= shiftIR | shiftDR.
  - trst clears both asynchronously.
- With TDO_NEGEDGE=0 the same logic is clocked on posedge.
- Boundary conditions:
  - tdo_en rises half a cycle after entering Shift-*, and falls half a cycle after leaving it. The first and last shifted bits are both driven.
  - trst asserted mid-shift: state is 0xF immediately (asynchronous), strobes drop in the same cycle, tdo_en=0.
  - trst deasserted: the first transition uses tms at the next posedge.
  - tms X/Z is not handled. The bench must keep tms defined.

Decomposition:
- Shared defines/package: tap_state_t enum with the 16 encodings above, plus TAP_STATE_W=4.
- Place them alongside the existing instruction encodings (E_*/D_*).
- Sub-module tap_tdo_stage: TDO mux plus edge-selectable output flops, parameterised by TDO_NEGEDGE.
- The FSM and output decode stay in tap_controller.

Test Plan:
- Reset recovery: pulse trst, then tms=0 for 1 clock -> state 0xC; tl_reset 1->0 at that posedge; tdo_en=0.
- Forced reset: from Shift-DR, five tms=1 clocks -> state sequence 0x2,0x1,0x5,0x7,0x4,0xF; tl_reset=1 after the 5th posedge.
- IR scan: from RTI apply tms 1,1,0,0,0,0,0,1,1.
  - Expect captureIR for 1 cycle, shiftIR for 4 cycles, then Exit1-IR, updateIR for 1 cycle.
  - ir_clk_en high for 5 cycles; select=1 throughout.
  - tdo carries ir_tdo values on negedges; tdo_en high for 4 half-cycle-offset cycles.
- DR scan with pause: Shift-DR -> Exit1 -> Pause x3 -> Exit2 -> Shift-DR.
  - shiftDR deasserted during the pause; tdo holds its last value; tdo_en=0 during the pause.
- Async reset mid-scan: assert trst between edges during Shift-IR.
  - Expect shiftIR=0, tl_reset=1, state=0xF and tdo_en=0 immediately, with no clock edge.
- Exhaustive arcs: for all 16 states x tms{0,1}, compare next state against the reference transition table (32 arcs).
